// File: rtl/fwd_scoreboard_if.sv
// Bundle of the forwarding scoreboard's issue, operand, result and writeback
// signals.
//   slave  : scoreboard side. It takes the i_* signals and drives the o_* signals.
//   master : datapath/decode side, with the directions reversed.
// Each signal keeps its datapath name, so wiring reads one-to-one against the CPU.
interface fwd_scoreboard_if #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int STAGES = 3,
  parameter int NRP    = 2
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(STAGES + 1);

  logic                             i_advance;
  logic                             i_issue_valid;
  logic                             i_issue_wr;
  logic [AW-1:0]                    i_issue_dest;
  logic [NRP-1:0]                   i_rs_used;
  logic [NRP-1:0][AW-1:0]           i_rs_addr;
  logic [NRP-1:0][DATA_W-1:0]       i_rf_data;
  logic [STAGES-1:0]                i_res_vld;
  logic [STAGES-1:0][DATA_W-1:0]    i_res_data;
  logic                             i_flush;
  logic [NRP-1:0][DATA_W-1:0]       o_op_data;
  logic [NRP-1:0]                   o_op_fwd;
  logic                             o_stall;
  logic                             o_wb_en;
  logic [AW-1:0]                    o_wb_dest;
  logic [DATA_W-1:0]                o_wb_data;
  logic [CW-1:0]                    o_inflight;
  logic                             o_underflow;

  modport slave (
    input  i_advance, i_issue_valid, i_issue_wr, i_issue_dest, i_rs_used,
           i_rs_addr, i_rf_data, i_res_vld, i_res_data, i_flush,
    output o_op_data, o_op_fwd, o_stall, o_wb_en, o_wb_dest, o_wb_data,
           o_inflight, o_underflow
  );

  modport master (
    output i_advance, i_issue_valid, i_issue_wr, i_issue_dest, i_rs_used,
           i_rs_addr, i_rf_data, i_res_vld, i_res_data, i_flush,
    input  o_op_data, o_op_fwd, o_stall, o_wb_en, o_wb_dest, o_wb_data,
           o_inflight, o_underflow
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and hazard unit for the pipelined CPU.
// It tracks STAGES in-flight destination entries. Entry 0 is the youngest, and
// entry STAGES-1 retires into the register file.
//   clk, reset : clock and synchronous active-low reset.
//   sb         : issue tags in, per-stage result posting, operand lookup with
//                forwarding, load-use stall, flush, writeback port,
//                in-flight count and sticky underflow.
module fwd_scoreboard #(
  parameter int DATA_W       = 16,
  parameter int NREGS        = 8,
  parameter int STAGES       = 3,
  parameter int NRP          = 2,
  parameter int FLUSH_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  fwd_scoreboard_if.slave sb
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(STAGES + 1);

  typedef struct packed {
    logic              vld;
    logic              wr;
    logic [AW-1:0]     dest;
    logic              dv;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t [STAGES-1:0]             ent_q, ent_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          uf_q;
  logic [STAGES-1:0]             eff_dv;
  logic [STAGES-1:0][DATA_W-1:0] eff_data;
  logic [NRP-1:0]                stall_p;
  logic                          stall, issue, ret_ok, ret_kill, uf_set;

  // A result posted this cycle counts as present immediately.
  // Forwarding and retirement both see it with zero latency.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      eff_dv[k]   = ent_q[k].dv | sb.i_res_vld[k];
      eff_data[k] = sb.i_res_vld[k] ? sb.i_res_data[k] : ent_q[k].data;
    end
  end

  // Per-port lookup. The scan runs from oldest to youngest, so the youngest
  // matching writer is the one left standing.
  for (genvar p = 0; p < NRP; p++) begin : g_port
    logic              hit, hit_dv;
    logic [DATA_W-1:0] hit_data;
    always_comb begin
      hit      = 1'b0;
      hit_dv   = 1'b0;
      hit_data = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (ent_q[k].vld && ent_q[k].wr && ent_q[k].dest == sb.i_rs_addr[p]) begin
          hit      = 1'b1;
          hit_dv   = eff_dv[k];
          hit_data = eff_data[k];
        end
      end
    end
    assign sb.o_op_fwd[p]  = hit & hit_dv;
    assign sb.o_op_data[p] = (hit & hit_dv) ? hit_data : sb.i_rf_data[p];
    assign stall_p[p]      = sb.i_rs_used[p] & hit & ~hit_dv;
  end

  assign stall = sb.i_issue_valid & (|stall_p);
  assign issue = sb.i_advance & sb.i_issue_valid & ~stall & ~sb.i_flush;

  // The retiring entry is only flushed when the flush window covers every stage.
  assign ret_kill = sb.i_flush && (FLUSH_STAGES >= STAGES);
  assign ret_ok   = sb.i_advance & ent_q[STAGES-1].vld & ent_q[STAGES-1].wr & ~ret_kill;
  assign uf_set   = ret_ok & ~eff_dv[STAGES-1];

  always_comb begin
    ent_d = ent_q;
    for (int k = 0; k < STAGES; k++) begin
      ent_d[k].dv   = eff_dv[k];
      ent_d[k].data = eff_data[k];
    end
    if (sb.i_advance) begin
      ent_d[0] = '0;
      if (issue) begin
        ent_d[0].vld  = 1'b1;
        ent_d[0].wr   = sb.i_issue_wr;
        ent_d[0].dest = sb.i_issue_dest;
      end
      for (int k = 1; k < STAGES; k++) begin
        ent_d[k]      = ent_q[k-1];
        ent_d[k].dv   = eff_dv[k-1];
        ent_d[k].data = eff_data[k-1];
      end
    end
    // Young stages die on flush. On an advance, the entry landing in the
    // first surviving stage came from the flushed window, so it dies too.
    if (sb.i_flush) begin
      for (int k = 0; k < STAGES; k++)
        if (k < FLUSH_STAGES || (sb.i_advance && k == FLUSH_STAGES))
          ent_d[k].vld = 1'b0;
    end
    cnt_d = '0;
    for (int k = 0; k < STAGES; k++)
      cnt_d = cnt_d + CW'(ent_d[k].vld);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_q <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      if (uf_set) uf_q <= 1'b1;
    end
  end

  assign sb.o_stall     = stall;
  assign sb.o_wb_en     = ret_ok & eff_dv[STAGES-1];
  assign sb.o_wb_dest   = ent_q[STAGES-1].dest;
  assign sb.o_wb_data   = eff_data[STAGES-1];
  assign sb.o_inflight  = cnt_q;
  assign sb.o_underflow = uf_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
module tb_fwd_scoreboard;
  localparam int DATA_W = 16, NREGS = 8, STAGES = 3, NRP = 2, FS = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fwd_scoreboard_if #(.DATA_W(DATA_W), .NREGS(NREGS), .STAGES(STAGES), .NRP(NRP)) bus ();

  fwd_scoreboard #(.DATA_W(DATA_W), .NREGS(NREGS), .STAGES(STAGES), .NRP(NRP),
                   .FLUSH_STAGES(FS)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.i_advance     = 1'b0;
    bus.i_issue_valid = 1'b0;
    bus.i_issue_wr    = 1'b0;
    bus.i_issue_dest  = '0;
    bus.i_rs_used     = '0;
    bus.i_rs_addr     = '0;
    bus.i_rf_data     = '0;
    bus.i_res_vld     = '0;
    bus.i_res_data    = '0;
    bus.i_flush       = 1'b0;
  endtask

  // Step past the next rising edge, then clear the inputs for the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic iss(input logic [2:0] d, input logic wr);
    bus.i_advance     = 1'b1;
    bus.i_issue_valid = 1'b1;
    bus.i_issue_wr    = wr;
    bus.i_issue_dest  = d;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    clr();
    // Reset state. Issue is held active during reset to show that reset wins.
    reset = 1'b0;
    tick(); iss(3'd3, 1'b1);
    tick(); iss(3'd3, 1'b1);
    tick(); reset = 1'b1;
    bus.i_rs_used = 2'b01; bus.i_rs_addr[0] = 3'd3; bus.i_rf_data[0] = 16'h1234;
    settle();
    chk("rst_inflight", 32'(bus.o_inflight), 32'd0);
    chk("rst_wb_en",    32'(bus.o_wb_en),    32'd0);
    chk("rst_stall",    32'(bus.o_stall),    32'd0);
    chk("rst_fwd",      32'(bus.o_op_fwd),   32'd0);
    chk("rst_op",       32'(bus.o_op_data[0]), 32'h1234);
    chk("rst_uf",       32'(bus.o_underflow), 32'd0);

    // 1. ALU back-to-back forward from stage 0.
    do_reset();
    tick(); iss(3'd3, 1'b1);
    tick(); iss(3'd4, 1'b0);
    bus.i_res_vld[0] = 1'b1; bus.i_res_data[0] = 16'h0042;
    bus.i_rs_used = 2'b01; bus.i_rs_addr[0] = 3'd3; bus.i_rf_data[0] = 16'h0000;
    settle();
    chk("alu_op",    32'(bus.o_op_data[0]), 32'h0042);
    chk("alu_fwd",   32'(bus.o_op_fwd[0]),  32'd1);
    chk("alu_stall", 32'(bus.o_stall),      32'd0);
    tick(); settle();
    chk("alu_infl", 32'(bus.o_inflight), 32'd2);

    // 2. Load-use stall. The stall inserts a bubble, then the data arrives in stage 1.
    do_reset();
    tick(); iss(3'd2, 1'b1);
    tick(); iss(3'd6, 1'b1);
    bus.i_rs_used = 2'b10; bus.i_rs_addr[1] = 3'd2; bus.i_rf_data[1] = 16'h5555;
    settle();
    chk("ld_stall1", 32'(bus.o_stall), 32'd1);
    chk("ld_fwd1",   32'(bus.o_op_fwd[1]), 32'd0);
    tick(); iss(3'd6, 1'b1);
    bus.i_rs_used = 2'b10; bus.i_rs_addr[1] = 3'd2; bus.i_rf_data[1] = 16'h5555;
    bus.i_res_vld[1] = 1'b1; bus.i_res_data[1] = 16'hBEEF;
    settle();
    chk("ld_infl",   32'(bus.o_inflight),   32'd1);
    chk("ld_op",     32'(bus.o_op_data[1]), 32'hBEEF);
    chk("ld_stall2", 32'(bus.o_stall),      32'd0);

    // 3. The youngest writer of r5 wins the lookup.
    do_reset();
    tick(); iss(3'd5, 1'b1);
    tick(); iss(3'd5, 1'b1);
    bus.i_res_vld[0] = 1'b1; bus.i_res_data[0] = 16'h1111;
    tick(); bus.i_advance = 1'b1;
    bus.i_res_vld[0] = 1'b1; bus.i_res_data[0] = 16'h2222;
    tick();
    bus.i_rs_used = 2'b11; bus.i_rs_addr[0] = 3'd5; bus.i_rs_addr[1] = 3'd5;
    bus.i_rf_data[0] = 16'h9999; bus.i_rf_data[1] = 16'h9999;
    settle();
    chk("pri_op0",  32'(bus.o_op_data[0]), 32'h2222);
    chk("pri_op1",  32'(bus.o_op_data[1]), 32'h2222);
    chk("pri_infl", 32'(bus.o_inflight),   32'd2);
    chk("pri_nowb", 32'(bus.o_wb_en),      32'd0);
    bus.i_advance = 1'b1;
    settle();
    chk("pri_wb",   32'(bus.o_wb_en),   32'd1);
    chk("pri_wbd",  32'(bus.o_wb_data), 32'h1111);

    // 4. Retire r1, with a same-cycle read covered by the stage-2 forward.
    do_reset();
    tick(); iss(3'd1, 1'b1);
    tick(); bus.i_advance = 1'b1;
    bus.i_res_vld[0] = 1'b1; bus.i_res_data[0] = 16'h00AA;
    tick(); bus.i_advance = 1'b1;
    tick(); bus.i_advance = 1'b1;
    bus.i_rs_used = 2'b01; bus.i_rs_addr[0] = 3'd1; bus.i_rf_data[0] = 16'h0000;
    settle();
    chk("ret_wb",   32'(bus.o_wb_en),      32'd1);
    chk("ret_dest", 32'(bus.o_wb_dest),    32'd1);
    chk("ret_data", 32'(bus.o_wb_data),    32'h00AA);
    chk("ret_op",   32'(bus.o_op_data[0]), 32'h00AA);
    chk("ret_fwd",  32'(bus.o_op_fwd[0]),  32'd1);

    // 5. Flush with three entries in flight. Only the oldest writes back.
    do_reset();
    tick(); iss(3'd1, 1'b1);
    tick(); iss(3'd2, 1'b1);
    bus.i_res_vld[0] = 1'b1; bus.i_res_data[0] = 16'h0011;
    tick(); iss(3'd3, 1'b1);
    bus.i_res_vld[0] = 1'b1; bus.i_res_data[0] = 16'h0022;
    tick(); iss(3'd4, 1'b1); bus.i_flush = 1'b1;
    settle();
    chk("fl_infl3", 32'(bus.o_inflight), 32'd3);
    chk("fl_wb",    32'(bus.o_wb_en),    32'd1);
    chk("fl_wbd",   32'(bus.o_wb_dest),  32'd1);
    chk("fl_wbdat", 32'(bus.o_wb_data),  32'h0011);
    tick(); bus.i_advance = 1'b1;
    bus.i_rs_used = 2'b01; bus.i_rs_addr[0] = 3'd2; bus.i_rf_data[0] = 16'h7777;
    settle();
    chk("fl_infl0", 32'(bus.o_inflight),   32'd0);
    chk("fl_nowb",  32'(bus.o_wb_en),      32'd0);
    chk("fl_op",    32'(bus.o_op_data[0]), 32'h7777);

    // 6a. Reset arrives mid-stream while stage 2 holds an entry with no data.
    do_reset();
    tick(); iss(3'd6, 1'b1);
    tick(); iss(3'd7, 1'b1);
    tick(); bus.i_advance = 1'b1;
    settle();
    chk("rs_infl2", 32'(bus.o_inflight), 32'd2);
    tick(); reset = 1'b0; bus.i_advance = 1'b1;
    tick(); reset = 1'b1;
    bus.i_rs_used = 2'b01; bus.i_rs_addr[0] = 3'd7; bus.i_rf_data[0] = 16'h3C3C;
    settle();
    chk("rs_infl0", 32'(bus.o_inflight),   32'd0);
    chk("rs_wb",    32'(bus.o_wb_en),      32'd0);
    chk("rs_uf",    32'(bus.o_underflow),  32'd0);
    chk("rs_op",    32'(bus.o_op_data[0]), 32'h3C3C);

    // 6b. Retiring a dataless writer sets the sticky underflow flag.
    tick(); iss(3'd6, 1'b1);
    tick(); bus.i_advance = 1'b1;
    tick(); bus.i_advance = 1'b1;
    tick(); bus.i_advance = 1'b1;
    settle();
    chk("uf_nowb", 32'(bus.o_wb_en),     32'd0);
    chk("uf_pre",  32'(bus.o_underflow), 32'd0);
    tick(); settle();
    chk("uf_set",  32'(bus.o_underflow), 32'd1);
    tick(); settle();
    chk("uf_hold", 32'(bus.o_underflow), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
